// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: consumes operands LSB-first, emits one registered result bit per cycle.
// Optional zero flag (port 'zero' plus accumulator) is built when ALU_ZERO_FLAG_EN is defined.
module bit_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       a_in,
    input  logic       b_in,
    output logic       shift_en,
    output logic       result_bit,
    output logic       result_valid,
    output logic       busy,
    output logic       done,
    output logic       carry_out
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic       zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_AND    = 3'b010;
    localparam logic [2:0] OP_OR     = 3'b011;
    localparam logic [2:0] OP_XOR    = 3'b100;
    localparam logic [2:0] OP_PASS_B = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic [2:0]    r_op;
    logic          r_shift_en;
    logic          r_result_bit;
    logic          r_result_valid;
    logic          r_busy;
    logic          r_done;
    logic          r_carry_out;
`ifdef ALU_ZERO_FLAG_EN
    logic          r_zero_acc;
    logic          r_zero;
`endif

    logic w_b;
    logic w_sum;
    logic w_carry_nxt;
    logic w_bit;
    logic w_arith;

    always_comb begin
        w_b         = (r_op == OP_SUB) ? ~b_in : b_in;
        w_sum       = a_in ^ w_b ^ r_carry;
        w_carry_nxt = (a_in & w_b) | (a_in & r_carry) | (w_b & r_carry);
        w_arith     = (r_op == OP_ADD) || (r_op == OP_SUB);
        case (r_op)
            OP_ADD, OP_SUB: w_bit = w_sum;
            OP_AND:         w_bit = a_in & b_in;
            OP_OR:          w_bit = a_in | b_in;
            OP_XOR:         w_bit = a_in ^ b_in;
            OP_PASS_B:      w_bit = b_in;
            default:        w_bit = a_in;  // PASS_A and the reserved opcode
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_carry        <= 1'b0;
            r_op           <= 3'b000;
            r_shift_en     <= 1'b0;
            r_result_bit   <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_carry_out    <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
            r_zero_acc     <= 1'b0;
            r_zero         <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op       <= op;
                        r_carry    <= (op == OP_SUB);
                        r_cnt      <= '0;
                        r_shift_en <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
`ifdef ALU_ZERO_FLAG_EN
                        r_zero_acc <= 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    r_result_bit   <= w_bit;
                    r_result_valid <= 1'b1;
                    if (w_arith) r_carry <= w_carry_nxt;
`ifdef ALU_ZERO_FLAG_EN
                    r_zero_acc <= r_zero_acc & ~w_bit;
`endif
                    // Flags are loaded here so they are already visible alongside done.
                    if (r_cnt == LAST) begin
                        r_state     <= S_FLUSH;
                        r_shift_en  <= 1'b0;
                        r_done      <= 1'b1;
                        r_carry_out <= w_arith ? w_carry_nxt : 1'b0;
`ifdef ALU_ZERO_FLAG_EN
                        r_zero      <= r_zero_acc & ~w_bit;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_done         <= 1'b0;
                    r_result_valid <= 1'b0;
                    r_busy         <= 1'b0;
                    r_cnt          <= '0;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign shift_en     = r_shift_en;
    assign result_bit   = r_result_bit;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign carry_out    = r_carry_out;
`ifdef ALU_ZERO_FLAG_EN
    assign zero         = r_zero;
`endif

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed bench for bit_serial_alu: arithmetic reference model plus per-cycle output comparison.
module tb_bit_serial_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic       shift_en, result_bit, result_valid, busy, done, carry_out;
`ifdef ALU_ZERO_FLAG_EN
    logic       zero;
`endif

    int checks = 0;
    int errors = 0;

    bit_serial_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .shift_en(shift_en), .result_bit(result_bit), .result_valid(result_valid),
        .busy(busy), .done(done), .carry_out(carry_out)
`ifdef ALU_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic, returns {zero, carry, result}.
    function automatic logic [9:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = 9'd0;
        case (o)
            3'b000:  s = {1'b0, a} + {1'b0, b};
            3'b001:  s = {1'b0, a} + {1'b0, ~b} + 9'd1;
            3'b010:  s = {1'b0, a & b};
            3'b011:  s = {1'b0, a | b};
            3'b100:  s = {1'b0, a ^ b};
            3'b110:  s = {1'b0, b};
            default: s = {1'b0, a};
        endcase
        return {(s[7:0] == 8'h00), s};
    endfunction

    int         cyc = 0;
    int         m_t0 = 0;
    bit         m_active = 1'b0;
    logic [7:0] m_r = 8'h00;
    logic       m_c = 1'b0;
    logic       m_z = 1'b0;
    logic [7:0] g_a = 8'h00;
    logic [7:0] g_b = 8'h00;
    logic [7:0] cap = 8'h00;
    int         sh_cnt = 0;
    int         done_cnt = 0;
    int         done_n = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
        end else begin
            if (start && !(m_active && (cyc - m_t0) <= 9)) begin
                {m_z, m_c, m_r} = model(op, g_a, g_b);
                m_t0     = cyc;
                m_active = 1'b1;
                cap      = 8'h00;
                sh_cnt   = 0;
                done_cnt = 0;
                done_n   = -1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        int n;
        n = cyc - m_t0;
        chk("shift_en", shift_en, m_active && n >= 1 && n <= 8);
        chk("result_valid", result_valid, m_active && n >= 2 && n <= 9);
        chk("busy", busy, m_active && n >= 1 && n <= 9);
        chk("done", done, m_active && n == 9);
        if (m_active && n >= 2 && n <= 9) chk("result_bit", result_bit, m_r[n-2]);
        if (!m_active || n >= 9) begin
            chk("carry_out", carry_out, m_active ? m_c : 1'b0);
`ifdef ALU_ZERO_FLAG_EN
            chk("zero", zero, m_active ? m_z : 1'b0);
`endif
        end
        if (result_valid) cap = {result_bit, cap[7:1]};
        if (shift_en) sh_cnt++;
        if (done) begin
            done_cnt++;
            done_n = n;
        end
    end

    // Start in cycle T, operand bit k in cycle T+1+k, returns at cycle T+10.
    task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] pmask, input int abort_n);
        g_a   = a;
        g_b   = b;
        start = 1'b1;
        op    = o;
        a_in  = 1'($urandom_range(0, 1));
        b_in  = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int n = 1; n <= 9; n++) begin
            start = pmask[n];
            op    = 3'($urandom_range(0, 7));
            if (n <= 8) begin
                a_in = a[n-1];
                b_in = b[n-1];
            end else begin
                a_in = 1'b0;
                b_in = 1'b0;
            end
            if (n == abort_n) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_shift_en", shift_en, 0);
                chk("rst_result_bit", result_bit, 0);
                chk("rst_result_valid", result_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_carry_out", carry_out, 0);
                chk("rst_state", 32'(dut.r_state), 0);
`ifdef ALU_ZERO_FLAG_EN
                chk("rst_zero", zero, 0);
`endif
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [7:0] exp_r, input logic exp_c, input logic exp_z);
        chk({name, "_result"}, cap, exp_r);
        chk({name, "_carry"}, carry_out, exp_c);
        chk({name, "_shifts"}, sh_cnt, 8);
        chk({name, "_dones"}, done_cnt, 1);
        chk({name, "_done_at"}, done_n, 9);
`ifdef ALU_ZERO_FLAG_EN
        chk({name, "_zero"}, zero, exp_z);
`else
        if (exp_z) checks += 0;
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_shift_en", shift_en, 0);
        chk("reset_valid", result_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_carry", carry_out, 0);
        chk("reset_bit", result_bit, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_op(3'b000, 8'h35, 8'h4A, 16'h0, 0);  check_op("add1", 8'h7F, 1'b0, 1'b0);
        do_op(3'b000, 8'hFF, 8'h01, 16'h0, 0);  check_op("add2", 8'h00, 1'b1, 1'b1);
        do_op(3'b001, 8'h10, 8'h01, 16'h0, 0);  check_op("sub1", 8'h0F, 1'b1, 1'b0);
        do_op(3'b001, 8'h00, 8'h01, 16'h0, 0);  check_op("sub2", 8'hFF, 1'b0, 1'b0);
        do_op(3'b010, 8'hF0, 8'h3C, 16'h0, 0);  check_op("and", 8'h30, 1'b0, 1'b0);
        do_op(3'b100, 8'hAA, 8'hFF, 16'h0, 0);  check_op("xor", 8'h55, 1'b0, 1'b0);
        do_op(3'b111, 8'h5A, 8'h33, 16'h0, 0);  check_op("rsvd", 8'h5A, 1'b0, 1'b0);
        do_op(3'b110, 8'h00, 8'hC3, 16'h0, 0);  check_op("passb", 8'hC3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Starts at T+1, T+4 and T+9 are ignored; the one at T+10 is accepted.
        do_op(3'b000, 8'h12, 8'h34, 16'h0212, 0);  check_op("ign", 8'h46, 1'b0, 1'b0);
        do_op(3'b011, 8'h0F, 8'hF0, 16'h0, 0);     check_op("or_b2b", 8'hFF, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        do_op(3'b001, 8'h80, 8'h80, 16'h0, 0);  check_op("sub3", 8'h00, 1'b1, 1'b1);
        do_op(3'b000, 8'hFF, 8'h00, 16'h0, 4);
        repeat (2) @(negedge clk);
        do_op(3'b000, 8'h01, 8'h01, 16'h0, 0);  check_op("add_post_rst", 8'h02, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
